// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, used by the operand fetch stage
// and by registerfile.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   pending_vec_t;

  function automatic pending_vec_t reg_onehot(input reg_addr_t addr);
    reg_onehot = pending_vec_t'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bundle of per-lane decode, register-file, writeback and execute signals
// around the operand fetch stage; master = fetch stage, slave = its surroundings.
interface regfile_operand_fetch_if #(
  parameter int cores = 1
);
  import regfile_pkg::*;

  logic      [cores-1:0] in_valid;
  logic      [cores-1:0] in_ready;
  reg_addr_t [cores-1:0] in_rs;
  reg_addr_t [cores-1:0] in_rt;
  reg_addr_t [cores-1:0] in_rd;
  logic      [cores-1:0] in_writes_rd;

  reg_addr_t [cores-1:0] read_address_1;
  reg_addr_t [cores-1:0] read_address_2;
  reg_data_t [cores-1:0] read_data_1;
  reg_data_t [cores-1:0] read_data_2;

  logic      [cores-1:0] wb_valid;
  reg_addr_t [cores-1:0] wb_address;
  reg_data_t [cores-1:0] wb_data;

  logic      [cores-1:0] out_valid;
  logic      [cores-1:0] out_ready;
  reg_data_t [cores-1:0] out_rs_data;
  reg_data_t [cores-1:0] out_rt_data;
  reg_addr_t [cores-1:0] out_rd;
  logic      [cores-1:0] out_writes_rd;

  modport master (
    input  in_valid, in_rs, in_rt, in_rd, in_writes_rd,
    input  read_data_1, read_data_2,
    input  wb_valid, wb_address, wb_data,
    input  out_ready,
    output in_ready, read_address_1, read_address_2,
    output out_valid, out_rs_data, out_rt_data, out_rd, out_writes_rd
  );

  modport slave (
    output in_valid, in_rs, in_rt, in_rd, in_writes_rd,
    output read_data_1, read_data_2,
    output wb_valid, wb_address, wb_data,
    output out_ready,
    input  in_ready, read_address_1, read_address_2,
    input  out_valid, out_rs_data, out_rt_data, out_rd, out_writes_rd
  );

endinterface

// File: rtl/opfetch_scoreboard.sv
// One lane's pending-register scoreboard: RAW/WAW hazard check and set/clear.
// REGFILE_OPFETCH_BYPASS_EN lets a same-cycle writeback relieve the hazard.
module opfetch_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t rs,
  input  reg_addr_t rt,
  input  reg_addr_t rd,
  input  logic      writes_rd,
  input  logic      accept,
  input  logic      wb_valid,
  input  reg_addr_t wb_address,
  output logic      stall,
  output logic      rs_fwd,
  output logic      rt_fwd
);

  pending_vec_t pending_q, pending_d;
  logic         rd_relief;

  always_comb begin : hazard_check
`ifdef REGFILE_OPFETCH_BYPASS_EN
    rs_fwd    = wb_valid && (wb_address == rs);
    rt_fwd    = wb_valid && (wb_address == rt);
    rd_relief = wb_valid && (wb_address == rd);
`else
    rs_fwd    = 1'b0;
    rt_fwd    = 1'b0;
    rd_relief = 1'b0;
`endif
    // Bit 0 is never set, so register 0 can never raise a hazard.
    stall = (pending_q[rs] && !rs_fwd) ||
            (pending_q[rt] && !rt_fwd) ||
            (writes_rd && (rd != '0) && pending_q[rd] && !rd_relief);
  end

  always_comb begin : pending_next
    pending_d = pending_q;
    if (wb_valid) begin
      pending_d = pending_d & ~reg_onehot(wb_address);
    end
    // Applied after the clear so a new producer of the same register wins.
    if (accept && writes_rd && (rd != '0)) begin
      pending_d = pending_d | reg_onehot(rd);
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Per-lane operand fetch between decode and execute, with scoreboard stall.
// Define REGFILE_OPFETCH_BYPASS_EN to forward writeback data into the operands.
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int cores = 1
) (
  input logic                     clk,
  input logic                     reset,
  regfile_operand_fetch_if.master bus
);

  logic      [cores-1:0] stall;
  logic      [cores-1:0] rs_fwd;
  logic      [cores-1:0] rt_fwd;
  logic      [cores-1:0] in_ready;
  logic      [cores-1:0] accept;

  logic      [cores-1:0] out_valid_q, out_valid_d;
  logic      [cores-1:0] out_writes_rd_q, out_writes_rd_d;
  reg_data_t [cores-1:0] out_rs_data_q, out_rs_data_d;
  reg_data_t [cores-1:0] out_rt_data_q, out_rt_data_d;
  reg_addr_t [cores-1:0] out_rd_q, out_rd_d;

  function automatic reg_data_t operand_value(input reg_addr_t addr,
                                              input logic      fwd,
                                              input reg_data_t wb_val,
                                              input reg_data_t rf_val);
    if (addr == '0) begin
      operand_value = '0;
    end else if (fwd) begin
      operand_value = wb_val;
    end else begin
      operand_value = rf_val;
    end
  endfunction

  for (genvar l = 0; l < cores; l++) begin : g_lane
    opfetch_scoreboard u_sb (
      .clk        (clk),
      .reset      (reset),
      .rs         (bus.in_rs[l]),
      .rt         (bus.in_rt[l]),
      .rd         (bus.in_rd[l]),
      .writes_rd  (bus.in_writes_rd[l]),
      .accept     (accept[l]),
      .wb_valid   (bus.wb_valid[l]),
      .wb_address (bus.wb_address[l]),
      .stall      (stall[l]),
      .rs_fwd     (rs_fwd[l]),
      .rt_fwd     (rt_fwd[l])
    );
  end

  always_comb begin : issue_ctrl
    in_ready = '0;
    accept   = '0;
    for (int l = 0; l < cores; l++) begin
      in_ready[l] = !stall[l] && (!out_valid_q[l] || bus.out_ready[l]);
      accept[l]   = bus.in_valid[l] && in_ready[l];
    end
  end

  always_comb begin : out_next
    out_valid_d     = out_valid_q;
    out_writes_rd_d = out_writes_rd_q;
    out_rs_data_d   = out_rs_data_q;
    out_rt_data_d   = out_rt_data_q;
    out_rd_d        = out_rd_q;
    for (int l = 0; l < cores; l++) begin
      if (accept[l]) begin
        out_valid_d[l]     = 1'b1;
        out_rs_data_d[l]   = operand_value(bus.in_rs[l], rs_fwd[l],
                                           bus.wb_data[l], bus.read_data_1[l]);
        out_rt_data_d[l]   = operand_value(bus.in_rt[l], rt_fwd[l],
                                           bus.wb_data[l], bus.read_data_2[l]);
        out_rd_d[l]        = bus.in_rd[l];
        out_writes_rd_d[l] = bus.in_writes_rd[l];
      end else if (out_valid_q[l] && bus.out_ready[l]) begin
        out_valid_d[l] = 1'b0;
      end
    end
  end

  // Execute-side output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= '0;
      out_writes_rd_q <= '0;
      out_rs_data_q   <= '0;
      out_rt_data_q   <= '0;
      out_rd_q        <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_rs_data_q   <= out_rs_data_d;
      out_rt_data_q   <= out_rt_data_d;
      out_rd_q        <= out_rd_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.read_address_1 = bus.in_rs;
  assign bus.read_address_2 = bus.in_rt;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_rs_data    = out_rs_data_q;
  assign bus.out_rt_data    = out_rt_data_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_writes_rd  = out_writes_rd_q;

endmodule

// File: doc/regfile_operand_fetch.md
# regfile_operand_fetch

Per-core operand fetch stage: the read-side initiator for `registerfile`. It accepts decoded instructions, drives the register file read ports, and captures operands into an output register. A per-core scoreboard stalls issue on RAW/WAW hazards, and writebacks are forwarded to the operands. It sits between decode and execute, with one lane per core, each lane mapping onto one `registerfile` lane.

## Interface
Parameters:
- `cores`, 1, number of independent lanes; every per-core port is a packed `[cores-1:0]` array

Ports (per-core widths shown per lane):
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  [cores-1:0]  decoded instruction present
- `in_ready`  out  [cores-1:0]  lane accepts the instruction this cycle
- `in_rs`, `in_rt`  in  [cores-1:0][4:0]  source register addresses
- `in_rd`  in  [cores-1:0][4:0]  destination address
- `in_writes_rd`  in  [cores-1:0]  instruction will write `in_rd`
- `read_address_1`, `read_address_2`  out  [cores-1:0][4:0]  to `registerfile`; combinationally equal to `in_rs` / `in_rt`
- `read_data_1`, `read_data_2`  in  [cores-1:0][31:0]  from `registerfile`; combinational read
- `wb_valid`  in  [cores-1:0]  writeback this cycle; the same signal drives the register file `write_enable`
- `wb_address`  in  [cores-1:0][4:0]  writeback register
- `wb_data`  in  [cores-1:0][31:0]  writeback value
- `out_valid`  out  [cores-1:0]  operands valid
- `out_ready`  in  [cores-1:0]  execute accepts
- `out_rs_data`, `out_rt_data`  out  [cores-1:0][31:0]  operand values
- `out_rd`  out  [cores-1:0][4:0]  destination register, passed through
- `out_writes_rd`  out  [cores-1:0]  write flag, passed through

## Operation
- Lanes are fully independent. No signal crosses between lanes.
- The scoreboard holds a 32-bit `pending` vector per lane. Bit r is set means an issued instruction has not yet written back r.
- Register 0 rules:
  - Register 0 is never pending.
  - An operand address of 0 yields 32'h0 regardless of `read_data_*`.
- A source operand is `ok` when either:
  - it is not pending, or
  - `wb_valid` is high and `wb_address` equals the operand address this cycle (forwarded; see Configuration).
- `stall` is asserted when either:
  - `in_rs` or `in_rt` is not `ok`, or
  - `in_writes_rd` is high, `in_rd` is nonzero, `in_rd` is pending, and `in_rd` is not being written back this cycle (WAW hazard).
- `in_ready = !stall && (!out_valid || out_ready)`. `in_ready` never depends on `in_valid`.
- Operand value priority: address 0 gives 0; otherwise a matching `wb_data` (forward); otherwise `read_data_*`.
- On an edge with `in_valid && in_ready` (accept):
  - The output register loads both operands, `in_rd`, and `in_writes_rd`.
  - `out_valid` is set.
- On an edge with `out_valid && out_ready` and no accept, `out_valid` clears.
- Scoreboard update per edge:
  - Clear `pending[wb_address]` when `wb_valid` is high.
  - Then set `pending[in_rd]` on an accept with `in_writes_rd` high and `in_rd` nonzero.
  - Set wins when set and clear hit the same register.
  - A writeback to a non-pending register is legal and has no scoreboard effect.
- Reset values: `out_valid`=0, `out_rs_data`=0, `out_rt_data`=0, `out_rd`=0, `out_writes_rd`=0, every `pending` bit = 0.
- Reset during an instruction in flight:
  - All pending hazards are dropped.
  - A later writeback for a dropped register is ignored by the scoreboard.

## Timing
- Latency: an instruction accepted at edge N has `out_valid` high from edge N through at least edge N+1.
- Throughput: one instruction per cycle per lane when there is no hazard and `out_ready` is held high.
- Holding rules:
  - While `out_valid && !out_ready`, all `out_*` signals hold stable.
  - `in_*` signals are not sampled.
- A forwarded operand costs zero stall cycles (with bypass enabled).
- A RAW dependence on the immediately preceding instruction stalls until its writeback cycle.

## Configuration
- `REGFILE_OPFETCH_BYPASS_EN` defined:
  - Writeback forwarding is active as described above.
  - The stall clears in the writeback cycle itself.
- Undefined:
  - No forwarding path exists; operands always come from `read_data_*` or zero.
  - A pending source is not `ok` in its writeback cycle. The lane stalls one extra cycle and reads the register file after the write has landed.
  - The WAW clear-in-same-cycle relief is also removed.

## Structure
- Shared package `regfile_pkg`:
  - Constants: `REG_ADDR_W`=5, `REG_DATA_W`=32, `NUM_REGS`=32.
  - Typedefs: `reg_addr_t`, `reg_data_t`, `pending_vec_t`.
  - `registerfile` uses the same constants.
- Sub-module `opfetch_scoreboard`:
  - One lane's pending vector, plus the set/clear and hazard-check logic.
  - Instantiated once per lane via generate.

## Test plan
- RAW forward:
  - `cores`=1. Issue rd=9 (`in_writes_rd`=1), then rs=9; `in_ready`=0.
  - Drive `wb_valid`=1, `wb_address`=9, `wb_data`=32'h0000_0015: the dependent instruction is accepted that cycle and `out_rs_data`=32'h15.
  - Without the macro it is accepted one cycle later with the same value.
- Zero register: rs=0 while `read_data_1`=32'hFFFF_FFFF -> `out_rs_data`=0; an instruction with rd=0 leaves `pending`=0.
- Backpressure: hold `out_ready`=0 with `out_valid`=1 -> `in_ready`=0 and `out_*` stable for 5 cycles; raising `out_ready` resumes at 1 instruction/cycle.
- Simultaneous set/clear: writeback to r15 in the same cycle that a new rd=15 instruction is accepted -> r15 remains pending; a following rs=15 stalls.
- Reset mid-flight: r15 pending, assert `reset` for one cycle -> `out_valid`=0 and a following rs=15 is accepted immediately with the `read_data_1` value.
- Lane isolation: `cores`=4. Lane 2 pending r5 does not stall rs=5 on lanes 0, 1, 3; per-lane `read_address_*` match each lane's `in_rs`/`in_rt`.
